hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_match.sv | 13 +
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding is compiled in only when HAZARD_FORWARD_EN is defined.
package hazard_pkg;

  localparam int REG_W         = 5;
  localparam int CANCEL_CYCLES = 2;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic             lw_en;
  } stage_t;

endpackage

// File: rtl/hazard_match.sv
// Producer/consumer match for one tracker entry against one source index.
module hazard_match
  import hazard_pkg::*;
(
  input  stage_t           ent,
  input  logic [REG_W-1:0] src,
  output logic             hit
);

  // x0 is hardwired to zero, so a write to it can never feed a consumer.
  assign hit = ent.valid && ent.wr_en && (ent.rd != '0) && (ent.rd == src);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, jump flush and EX operand-forward control for a 5-stage pipe.
// Define HAZARD_FORWARD_EN to enable forwarding; otherwise RAW hazards stall.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_en,
  input  logic             id_lw_en,
  input  logic             ex_jmp_en,
  output logic             stall,
  output logic             cancel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  stage_t     id_ent;
  stage_t     trk_ex_p0;
  stage_t     trk_mem_p1;
  stage_t     trk_wb_p2;
  logic [1:0] cnt_q;
  logic [1:0] cnt_nxt;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;
  logic       hit_ex_rs1;
  logic       hit_ex_rs2;
  logic       hit_mem_rs1;
  logic       hit_mem_rs2;
  logic       stall_cond;
  logic       bubble;
  logic       unused_trk;

  assign id_ent = '{valid: id_valid, rd: id_rd, wr_en: id_wr_en, lw_en: id_lw_en};

  hazard_match u_match_ex_rs1  (.ent(trk_ex_p0),  .src(id_rs1), .hit(hit_ex_rs1));
  hazard_match u_match_ex_rs2  (.ent(trk_ex_p0),  .src(id_rs2), .hit(hit_ex_rs2));
  hazard_match u_match_mem_rs1 (.ent(trk_mem_p1), .src(id_rs1), .hit(hit_mem_rs1));
  hazard_match u_match_mem_rs2 (.ent(trk_mem_p1), .src(id_rs2), .hit(hit_mem_rs2));

`ifdef HAZARD_FORWARD_EN
  // The younger producer (about to enter MEM) holds the newest value.
  function automatic logic [1:0] fwd_sel(input logic hit_mem, input logic hit_wb);
    if (hit_mem)     return FWD_MEM;
    else if (hit_wb) return FWD_WB;
    else             return FWD_REG;
  endfunction

  assign stall_cond = trk_ex_p0.lw_en && (hit_ex_rs1 || hit_ex_rs2);
  assign fwd_a_nxt  = bubble ? FWD_REG : fwd_sel(hit_ex_rs1, hit_mem_rs1);
  assign fwd_b_nxt  = bubble ? FWD_REG : fwd_sel(hit_ex_rs2, hit_mem_rs2);
`else
  // Without bypass paths any in-flight producer blocks the reader until
  // it reaches WB, where the regfile write lands before the read.
  assign stall_cond = hit_ex_rs1 || hit_ex_rs2 || hit_mem_rs1 || hit_mem_rs2;
  assign fwd_a_nxt  = FWD_REG;
  assign fwd_b_nxt  = FWD_REG;
`endif

  assign stall  = !rst && !cancel && id_valid && stall_cond;
  assign bubble = stall || cancel || !id_valid;

  always_comb begin
    cnt_nxt = cnt_q;
    if (cnt_q != 2'd0)
      cnt_nxt = cnt_q - 2'd1;
    else if (ex_jmp_en)
      cnt_nxt = 2'(CANCEL_CYCLES);
  end

  // ID -> EX -> MEM -> WB tracker boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_ex_p0.valid  <= 1'b0;
      trk_mem_p1.valid <= 1'b0;
      trk_wb_p2.valid  <= 1'b0;
      cnt_q            <= 2'd0;
      cancel           <= 1'b0;
      fwd_a            <= FWD_REG;
      fwd_b            <= FWD_REG;
    end else begin
      trk_wb_p2  <= trk_mem_p1;
      trk_mem_p1 <= trk_ex_p0;
      trk_ex_p0  <= bubble ? '{valid: 1'b0, rd: id_rd, wr_en: 1'b0, lw_en: 1'b0} : id_ent;
      cnt_q      <= cnt_nxt;
      cancel     <= (cnt_nxt != 2'd0);
      fwd_a      <= fwd_a_nxt;
      fwd_b      <= fwd_b_nxt;
    end
  end

  // WB entry and MEM load flag document the pipe but feed no decision.
  assign unused_trk = ^{trk_wb_p2, trk_mem_p1.lw_en, trk_ex_p0.lw_en};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random traffic.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, id_valid, id_wr_en, id_lw_en, ex_jmp_en;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, cancel;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_lw_en(id_lw_en), .ex_jmp_en(ex_jmp_en),
    .stall(stall), .cancel(cancel), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // Reference model: list of instructions issued into EX, newest first.
  typedef struct { bit v; int rd; bit wr; bit lw; } instr_t;
  instr_t   hist[$];
  int       cyc = 0;
  int       last_jmp = -100;
  bit [1:0] m_fwd_a = 2'b00, m_fwd_b = 2'b00;
  bit       exp_stall, exp_cancel;
  int       n_checks = 0, n_errors = 0;

  // age 0 = instruction now in EX, age 1 = now in MEM
  function automatic bit writes(int age, logic [4:0] r);
    if (age >= hist.size()) return 1'b0;
    return hist[age].v && hist[age].wr && hist[age].rd != 0 && hist[age].rd == int'(r);
  endfunction

  function automatic bit reads_from(int age);
    return writes(age, id_rs1) || writes(age, id_rs2);
  endfunction

  function automatic bit ex_is_load();
    return hist.size() > 0 && hist[0].v && hist[0].lw;
  endfunction

  task automatic set_in(input bit v, input int rs1, input int rs2, input int rd,
                        input bit wr, input bit lw, input bit jmp, input bit r);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_wr_en = wr; id_lw_en = lw; ex_jmp_en = jmp; rst = r;
    #1;
    exp_cancel = (cyc - last_jmp == 1) || (cyc - last_jmp == 2);
    if (FWD) exp_stall = !r && !exp_cancel && v && ex_is_load() && reads_from(0);
    else     exp_stall = !r && !exp_cancel && v && (reads_from(0) || reads_from(1));
  endtask

  task automatic tick();
    instr_t e;
    bit     bub;
    if (rst) begin
      hist.delete();
      last_jmp = -100;
      m_fwd_a = 2'b00;
      m_fwd_b = 2'b00;
    end else begin
      bub = exp_stall || exp_cancel || !id_valid;
      m_fwd_a = (!FWD || bub) ? 2'b00 : writes(0, id_rs1) ? 2'b01 : writes(1, id_rs1) ? 2'b10 : 2'b00;
      m_fwd_b = (!FWD || bub) ? 2'b00 : writes(0, id_rs2) ? 2'b01 : writes(1, id_rs2) ? 2'b10 : 2'b00;
      if (ex_jmp_en && !exp_cancel) last_jmp = cyc;
      if (bub) e = '{1'b0, 0, 1'b0, 1'b0};
      else     e = '{1'b1, int'(id_rd), id_wr_en, id_lw_en};
      hist.push_front(e);
      if (hist.size() > 2) void'(hist.pop_back());
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Holds an instruction in ID until it issues; ns = number of stall cycles.
  task automatic issue(input bit v, input int rs1, input int rs2, input int rd,
                       input bit wr, input bit lw, output int ns);
    ns = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(v, rs1, rs2, rd, wr, lw, 0, 0);
      if (stall !== 1'b1) break;
      ns++;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1, 1,
             1'($urandom_range(0, 1)), 1);
      n_checks++;
      if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      tick();
    end
    nop();
    n_checks++;
    if (cancel !== 1'b0) begin n_errors++; $display("FAIL reset_cancel: got %b expected 0", cancel); end
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      n_errors++; $display("FAIL reset_fwd: got %b/%b expected 00/00", fwd_a, fwd_b);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int ns;
    do_reset();
    issue(1, 1, 2, 5, 1, 0, ns);
    issue(1, 5, 3, 6, 1, 0, ns);
    n_checks++;
    if (ns != (FWD ? 0 : 2)) begin n_errors++; $display("FAIL b2b_stall_cycles: got %0d expected %0d", ns, FWD ? 0 : 2); end
    nop();
    n_checks++;
    if (fwd_a !== (FWD ? 2'b01 : 2'b00) || fwd_b !== 2'b00) begin
      n_errors++; $display("FAIL b2b_fwd: got %b/%b expected %b/00", fwd_a, fwd_b, FWD ? 2'b01 : 2'b00);
    end
    tick();
  endtask

  task automatic test_fwd_wb();
    int ns;
    do_reset();
    issue(1, 1, 2, 5, 1, 0, ns);
    issue(0, 0, 0, 0, 0, 0, ns);
    issue(1, 4, 5, 7, 1, 0, ns);
    n_checks++;
    if (ns != (FWD ? 0 : 1)) begin n_errors++; $display("FAIL wb_stall_cycles: got %0d expected %0d", ns, FWD ? 0 : 1); end
    nop();
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== (FWD ? 2'b10 : 2'b00)) begin
      n_errors++; $display("FAIL wb_fwd: got %b/%b expected 00/%b", fwd_a, fwd_b, FWD ? 2'b10 : 2'b00);
    end
    tick();
  endtask

  task automatic test_load_use();
    int ns;
    do_reset();
    issue(1, 2, 0, 8, 1, 1, ns);
    issue(1, 8, 8, 9, 1, 0, ns);
    n_checks++;
    if (ns != (FWD ? 1 : 2)) begin n_errors++; $display("FAIL lu_stall_cycles: got %0d expected %0d", ns, FWD ? 1 : 2); end
    nop();
    // After the bubble the load has moved on to WB when the add enters EX.
    n_checks++;
    if (fwd_a !== (FWD ? 2'b10 : 2'b00) || fwd_b !== (FWD ? 2'b10 : 2'b00)) begin
      n_errors++; $display("FAIL lu_fwd: got %b/%b expected %b/%b", fwd_a, fwd_b,
                           FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
    end
    tick();
  endtask

  task automatic test_x0();
    int ns;
    do_reset();
    issue(1, 1, 2, 0, 1, 0, ns);
    issue(1, 0, 0, 3, 1, 0, ns);
    n_checks++;
    if (ns != 0) begin n_errors++; $display("FAIL x0_stall: got %0d expected 0", ns); end
    nop();
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_errors++; $display("FAIL x0_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); end
    tick();
    issue(1, 1, 1, 0, 1, 1, ns);
    issue(1, 0, 0, 4, 1, 0, ns);
    n_checks++;
    if (ns != 0) begin n_errors++; $display("FAIL x0_load_stall: got %0d expected 0", ns); end
  endtask

  task automatic test_jump_flush();
    do_reset();
    set_in(1, 2, 0, 8, 1, 1, 1, 0);
    n_checks++;
    if (stall !== 1'b0 || cancel !== 1'b0) begin n_errors++; $display("FAIL jmp_c0: got stall=%b cancel=%b expected 0/0", stall, cancel); end
    tick();
    set_in(1, 8, 8, 9, 1, 0, 1, 0);
    n_checks++;
    if (cancel !== 1'b1 || stall !== 1'b0) begin n_errors++; $display("FAIL jmp_c1: got cancel=%b stall=%b expected 1/0", cancel, stall); end
    tick();
    set_in(1, 8, 9, 10, 1, 0, 1, 0);
    n_checks++;
    if (cancel !== 1'b1 || stall !== 1'b0) begin n_errors++; $display("FAIL jmp_c2: got cancel=%b stall=%b expected 1/0", cancel, stall); end
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_errors++; $display("FAIL jmp_c2_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); end
    tick();
    // Readers of the flushed results must see no producer in flight.
    set_in(1, 9, 10, 11, 1, 0, 0, 0);
    n_checks++;
    if (cancel !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL jmp_c3: got cancel=%b stall=%b expected 0/0", cancel, stall); end
    tick();
    nop();
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || cancel !== 1'b0) begin
      n_errors++; $display("FAIL jmp_c4: got fwd=%b/%b cancel=%b expected 00/00/0", fwd_a, fwd_b, cancel);
    end
    tick();
  endtask

  task automatic test_reset_midflush();
    do_reset();
    set_in(1, 1, 2, 5, 1, 0, 1, 0);
    tick();
    set_in(1, 5, 5, 6, 1, 0, 0, 1);
    n_checks++;
    if (cancel !== 1'b1 || stall !== 1'b0) begin n_errors++; $display("FAIL mrst_c1: got cancel=%b stall=%b expected 1/0", cancel, stall); end
    tick();
    set_in(1, 5, 5, 6, 1, 0, 0, 0);
    n_checks++;
    if (cancel !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL mrst_c2: got cancel=%b stall=%b expected 0/0", cancel, stall); end
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_errors++; $display("FAIL mrst_c2_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); end
    tick();
    nop();
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || cancel !== 1'b0) begin
      n_errors++; $display("FAIL mrst_c3: got fwd=%b/%b cancel=%b expected 00/00/0", fwd_a, fwd_b, cancel);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 49) == 0);
      n_checks++;
      if (stall !== exp_stall) begin n_errors++; $display("FAIL rnd_stall @%0d: got %b expected %b", i, stall, exp_stall); end
      n_checks++;
      if (cancel !== exp_cancel) begin n_errors++; $display("FAIL rnd_cancel @%0d: got %b expected %b", i, cancel, exp_cancel); end
      n_checks++;
      if (fwd_a !== m_fwd_a) begin n_errors++; $display("FAIL rnd_fwd_a @%0d: got %b expected %b", i, fwd_a, m_fwd_a); end
      n_checks++;
      if (fwd_b !== m_fwd_b) begin n_errors++; $display("FAIL rnd_fwd_b @%0d: got %b expected %b", i, fwd_b, m_fwd_b); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_fwd_wb();
    test_load_use();
    test_x0();
    test_jump_flush();
    test_reset_midflush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
